// File: rtl/cfg_shadow_bank_pkg.sv
// Shared parameters for the shadowed configuration bank: bus widths, control-word
// bit positions and apply-FSM state encodings.
package cfg_shadow_bank_pkg;

  localparam int MSB              = 15;
  localparam int MSB_REGS_ADDRESS = 7;

  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_LOCK_BIT  = 1;
  localparam int CTRL_DIRTY_BIT = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } apply_state_e;

endpackage

// File: rtl/cfg_shadow_cell.sv
// One shadow/active register pair: bus writes land in the shadow, and the apply
// pulse copies the shadow (as it was before this edge) into the active copy.
module cfg_shadow_cell
  import cfg_shadow_bank_pkg::*;
#(
  parameter int DATA_W = MSB + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              apply_i,
  input  logic [DATA_W-1:0] rst_val_i,
  output logic [DATA_W-1:0] shadow_o,
  output logic [DATA_W-1:0] active_o
);

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;

  always_comb begin
    shadow_d = wr_en_i ? wr_data_i : shadow_q;
    active_d = apply_i ? shadow_q  : active_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= rst_val_i;
      active_q <= rst_val_i;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;

endmodule

// File: rtl/cfg_shadow_bank.sv
// Bank of shadowed config registers, applied atomically on an armed sync strobe.
// Build option: define CFG_BANK_LOCK_EN to add a write-lock bit to the control word.
module cfg_shadow_bank
  import cfg_shadow_bank_pkg::*;
#(
  parameter int                         NUM_REGS  = 4,
  parameter int                         DATA_W    = MSB + 1,
  parameter int                         ADDR_W    = MSB_REGS_ADDRESS + 1,
  parameter int                         BASE_ADDR = 0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic                         cfg_re,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [DATA_W-1:0]            cfg_data_in,
  output logic [DATA_W-1:0]            cfg_data_out,
  output logic                         cfg_rd_valid,
  output logic                         cfg_wr_err,
  input  logic                         apply_stb,
  output logic                         applied,
  output logic [NUM_REGS*DATA_W-1:0]   reg_data_out
);

  // Bus semantics: cfg_we/cfg_re are single-cycle strobes with no back-pressure.
  // A read issued at cycle t returns at t+1 with cfg_rd_valid high for one cycle;
  // cfg_data_out keeps the last returned value otherwise.

  apply_state_e               state_q;
  logic                       dirty_q;
  logic                       applied_q;
  logic                       rd_valid_q;
  logic                       wr_err_q;
  logic [DATA_W-1:0]          data_out_q;
  logic [DATA_W-1:0]          rd_data_d;
  logic [NUM_REGS-1:0]        data_hit;
  logic [NUM_REGS-1:0]        wr_en;
  logic                       ctrl_hit;
  logic                       ctrl_wr;
  logic                       data_wr;
  logic                       data_wr_rej;
  logic                       apply_fire;
  logic                       lock;
  logic [NUM_REGS*DATA_W-1:0] shadow_flat;

  always_comb begin
    data_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      data_hit[i] = (cfg_addr == ADDR_W'(BASE_ADDR + i));
    end
  end

  assign ctrl_hit    = (cfg_addr == ADDR_W'(BASE_ADDR + NUM_REGS));
  assign ctrl_wr     = cfg_we && ctrl_hit;
  assign wr_en       = (cfg_we && !lock) ? data_hit : '0;
  assign data_wr     = |wr_en;
  assign data_wr_rej = cfg_we && lock && (|data_hit);
  assign apply_fire  = (state_q == ST_ARMED) && apply_stb;

`ifdef CFG_BANK_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (ctrl_wr) begin
      lock_q <= cfg_data_in[CTRL_LOCK_BIT];
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    cfg_shadow_cell #(
      .DATA_W (DATA_W)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en[g]),
      .wr_data_i (cfg_data_in),
      .apply_i   (apply_fire),
      .rst_val_i (RESET_VAL[g*DATA_W +: DATA_W]),
      .shadow_o  (shadow_flat[g*DATA_W +: DATA_W]),
      .active_o  (reg_data_out[g*DATA_W +: DATA_W])
    );
  end

  // A control write in the apply cycle decides the final state, so arm+apply stays armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dirty_q   <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      applied_q <= apply_fire;
      if (apply_fire) begin
        state_q <= ST_IDLE;
        dirty_q <= 1'b0;
      end
      if (ctrl_wr) begin
        state_q <= cfg_data_in[CTRL_ARM_BIT] ? ST_ARMED : ST_IDLE;
      end
      if (data_wr) begin
        dirty_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (data_hit[i]) begin
        rd_data_d = shadow_flat[i*DATA_W +: DATA_W];
      end
    end
    if (ctrl_hit) begin
      rd_data_d[CTRL_ARM_BIT]   = (state_q == ST_ARMED);
      rd_data_d[CTRL_LOCK_BIT]  = lock;
      rd_data_d[CTRL_DIRTY_BIT] = dirty_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= cfg_re;
      wr_err_q   <= data_wr_rej;
      if (cfg_re) begin
        data_out_q <= rd_data_d;
      end
    end
  end

  assign cfg_data_out = data_out_q;
  assign cfg_rd_valid = rd_valid_q;
  assign cfg_wr_err   = wr_err_q;
  assign applied      = applied_q;

endmodule

// File: tb/tb_cfg_shadow_bank.sv
// Scoreboard bench for cfg_shadow_bank: directed scenarios then random traffic,
// checked against an array-based model of the register bank.
module tb_cfg_shadow_bank;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic              re;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     din;
  logic              apply_stb;
  logic [DW-1:0]     cfg_data_out;
  logic              cfg_rd_valid;
  logic              cfg_wr_err;
  logic              applied;
  logic [NR*DW-1:0]  reg_data_out;

  typedef struct {
    logic             applied;
    logic             wr_err;
    logic             rd_valid;
    logic [DW-1:0]    dout;
    logic [NR*DW-1:0] active;
  } st_t;

  logic [DW-1:0] exp_q[$];
  st_t           st_q[$];

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sh_m[NR];
  logic [DW-1:0] ac_m[NR];
  bit            armed_m;
  bit            lock_m;
  bit            dirty_m;
  logic [DW-1:0] dout_m;

  cfg_shadow_bank #(
    .NUM_REGS  (NR),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .BASE_ADDR (0),
    .RESET_VAL ('0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (we),
    .cfg_re       (re),
    .cfg_addr     (addr),
    .cfg_data_in  (din),
    .cfg_data_out (cfg_data_out),
    .cfg_rd_valid (cfg_rd_valid),
    .cfg_wr_err   (cfg_wr_err),
    .apply_stb    (apply_stb),
    .applied      (applied),
    .reg_data_out (reg_data_out)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one call per clock edge, using the inputs the DUT sees
  task automatic step();
    st_t           e;
    logic [DW-1:0] rv;
    bit            fire;
    bit            wrote;
    bit            err;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        sh_m[i] = '0;
        ac_m[i] = '0;
      end
      armed_m = 0;
      lock_m  = 0;
      dirty_m = 0;
      dout_m  = '0;
      fire    = 0;
      err     = 0;
    end else begin
      rv = '0;
      if (addr < NR) rv = sh_m[addr[1:0]];
      else if (addr == NR) rv = {13'b0, dirty_m, lock_m, armed_m};
      if (re) begin
        exp_q.push_back(rv);
        dout_m = rv;
      end
      fire  = armed_m && apply_stb;
      wrote = 0;
      err   = 0;
      if (fire) begin
        for (int i = 0; i < NR; i++) ac_m[i] = sh_m[i];
      end
      if (we && addr < NR) begin
        if (lock_m) err = 1;
        else begin
          sh_m[addr[1:0]] = din;
          wrote = 1;
        end
      end
      if (fire) begin
        armed_m = 0;
        dirty_m = 0;
      end
      if (wrote) dirty_m = 1;
      if (we && addr == NR) begin
        armed_m = din[0];
`ifdef CFG_BANK_LOCK_EN
        lock_m = din[1];
`endif
      end
    end
    e.applied  = fire;
    e.wr_err   = err;
    e.rd_valid = re && !rst;
    e.dout     = dout_m;
    for (int i = 0; i < NR; i++) e.active[i*DW +: DW] = ac_m[i];
    st_q.push_back(e);
    #1;
  endtask

  task automatic op(input bit w, input bit r, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input bit ap);
    we = w;
    re = r;
    addr = a;
    din = d;
    apply_stb = ap;
    step();
  endtask

  // monitor / scoreboard
  initial begin
    st_t e;
    forever begin
      @(negedge clk);
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("applied", 64'(applied), 64'(e.applied));
        chk("wr_err", 64'(cfg_wr_err), 64'(e.wr_err));
        chk("rd_valid", 64'(cfg_rd_valid), 64'(e.rd_valid));
        chk("active", 64'(reg_data_out), 64'(e.active));
        if (cfg_rd_valid === 1'b1) begin
          if (exp_q.size() == 0) chk("rd_unexpected", 64'(cfg_data_out), 64'hDEAD_0000_0000);
          else chk("rd_data", 64'(cfg_data_out), 64'(exp_q.pop_front()));
        end else begin
          chk("dout_hold", 64'(cfg_data_out), 64'(e.dout));
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    op(0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int a = 0; a <= NR; a++) op(0, 1, AW'(a), 0, 0);

    // write without arm: apply ignored
    op(1, 0, 1, 16'h1234, 0);
    op(0, 0, 0, 0, 1);
    op(0, 1, 1, 0, 0);
    op(0, 1, NR, 0, 0);

    // full armed apply
    for (int i = 0; i < NR; i++) op(1, 0, AW'(i), 16'hA0 + 16'(i), 0);
    op(1, 0, NR, 16'h1, 0);
    op(0, 0, 0, 0, 1);
    op(0, 1, NR, 0, 0);

    // same-cycle data write and apply
    op(1, 0, 2, 16'h11, 0);
    op(1, 0, NR, 16'h1, 0);
    op(0, 0, 0, 0, 1);
    op(1, 0, NR, 16'h1, 0);
    op(1, 0, 2, 16'h55, 1);
    op(0, 1, 2, 0, 0);
    op(0, 1, NR, 0, 0);

    // arm write while armed and applying, then apply again
    op(1, 0, NR, 16'h1, 0);
    op(1, 0, NR, 16'h1, 1);
    op(0, 1, NR, 0, 0);
    op(0, 0, 0, 0, 1);

    // lock then data write, read-during-write, unlock
    op(1, 0, NR, 16'h2, 0);
    op(1, 1, 0, 16'h77, 0);
    op(0, 1, 0, 0, 0);
    op(0, 1, NR, 0, 0);
    op(1, 0, NR, 16'h0, 0);
    op(0, 0, 7, 0, 0);

    // reset while armed with dirty shadows
    op(1, 0, 3, 16'hBEEF, 0);
    op(1, 0, NR, 16'h1, 0);
    rst = 1'b1;
    op(0, 0, 0, 0, 0);
    rst = 1'b0;
    op(0, 0, 0, 0, 1);
    for (int a = 0; a <= NR; a++) op(0, 1, AW'(a), 0, 0);

    // random traffic including unmapped addresses and rare resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 6)),
         16'($urandom), ($urandom_range(0, 3) == 0));
    end
    rst = 1'b0;
    op(0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("exp_q_drain", 64'(exp_q.size()), 64'd0);
    chk("st_q_drain", 64'(st_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
